// File: rtl/counter_capture.sv
// counter_capture: free-running counter with synchronized event capture, wrap tracking and overrun flag
module counter_capture #(
    parameter int bits     = 8,
    parameter int maxvalue = 0,
    parameter int restart  = 0
) (
    input  logic            c,
    input  logic            clr,
    input  logic            en,
    input  logic            evt,
    input  logic            ack,
    output logic [bits-1:0] count,
    output logic [bits-1:0] cap,
    output logic            valid,
    output logic            wrap,
    output logic            miss
);
    localparam logic [bits-1:0] max_v = (maxvalue == 0) ? {bits{1'b1}} : bits'(maxvalue);
    localparam logic [bits-1:0] one_v = bits'(1);

    logic            s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [bits-1:0] count_q, count_d, cap_q, cap_d;
    logic            valid_q, valid_d, wrap_q, wrap_d, miss_q, miss_d;
    logic            wrap_pend_q, wrap_pend_d;
    logic            rise, wrap_ev, reload;

    // Next-state logic: capture on a synchronized rising edge of evt; a wrap in the capture cycle belongs to the next interval
    always_comb begin
        rise        = s1_q & ~s2_q;
        wrap_ev     = en & (count_q == max_v);
        reload      = (restart != 0) & rise;
        s0_d        = evt;
        s1_d        = s0_q;
        s2_d        = s1_q;
        count_d     = reload ? '0 : en ? (wrap_ev ? '0 : count_q + one_v) : count_q;
        cap_d       = rise ? count_q : cap_q;
        wrap_d      = rise ? wrap_pend_q : wrap_q;
        wrap_pend_d = reload ? 1'b0 : rise ? wrap_ev : (wrap_pend_q | wrap_ev);
        valid_d     = rise ? 1'b1 : ack ? 1'b0 : valid_q;
        miss_d      = miss_q | (rise & valid_q & ~ack);
    end

    // State registers with asynchronous clear
    always_ff @(posedge c or posedge clr) begin
        if (clr) begin
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            count_q     <= '0;
            cap_q       <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
            miss_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
        end else begin
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            count_q     <= count_d;
            cap_q       <= cap_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
            miss_q      <= miss_d;
            wrap_pend_q <= wrap_pend_d;
        end
    end

    assign count = count_q;
    assign cap   = cap_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;
    assign miss  = miss_q;
endmodule
